uart_alu_interface: RTL and testbench

UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

---
 rtl/uart_alu_interface.sv | 122 ++++++++++++
 tb/tb_uart_alu_interface.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_interface.sv
// UART <-> ALU glue: collects A, B and opcode bytes from the receiver, drives
// the ALU operands, then transmits the result byte followed by a flag byte.
module uart_alu_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_negative,
    input  logic                  i_zero,
    input  logic                  i_carry,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy
);

    // Counter is sized for TIMEOUT_CYCLES; a zero setting keeps a 1-bit stub.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Timeout fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic [7:0]    flg_q;
    logic          to_hit;

    // Receiver byte bits above the operand/opcode width are intentionally dropped.
    logic unused_rx_bits;
    assign unused_rx_bits = ^i_rx_data;

    assign to_hit = TO_EN && (to_cnt == TO_LAST);

    // Main control FSM; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            to_cnt     <= '0;
            flg_q      <= '0;
            o_a        <= '0;
            o_b        <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            to_cnt <= '0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_a   <= i_rx_data[DATA_WIDTH-1:0];
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_b   <= i_rx_data[DATA_WIDTH-1:0];
                        state <= WAIT_OP;
                    end else if (to_hit) begin
                        state <= WAIT_A;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op   <= i_rx_data[OP_WIDTH-1:0];
                        o_busy <= 1'b1;
                        state  <= EXEC;
                    end else if (to_hit) begin
                        state <= WAIT_A;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                // ALU has settled on the new operands; capture result and flags
                // and raise the start strobe so it is high during SEND_RES.
                EXEC: begin
                    o_tx_data  <= 8'(i_result);
                    flg_q      <= {5'b0, i_carry, i_zero, i_negative};
                    o_tx_start <= 1'b1;
                    state      <= SEND_RES;
                end
                SEND_RES: begin
                    o_tx_start <= 1'b0;
                    state      <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (i_tx_done) begin
                        o_tx_data  <= flg_q;
                        o_tx_start <= 1'b1;
                        state      <= SEND_FLG;
                    end
                end
                SEND_FLG: begin
                    o_tx_start <= 1'b0;
                    state      <= WAIT_FLG;
                end
                WAIT_FLG: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small behavioural ALU attached.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] result;
    logic       negative, zero, carry;
    logic [7:0] a, b;
    logic [5:0] op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(10)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_result(result), .i_negative(negative),
        .i_zero(zero), .i_carry(carry), .o_a(a), .o_b(b), .o_op(op),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy)
    );

    // ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25; carry only from ADD.
    always_comb begin
        logic [8:0] s;
        s = 9'h0;
        case (op)
            6'h20:   s = {1'b0, a} + {1'b0, b};
            6'h22:   s = {1'b0, a - b};
            6'h24:   s = {1'b0, a & b};
            6'h25:   s = {1'b0, a | b};
            default: s = 9'h0;
        endcase
        result   = s[7:0];
        carry    = s[8];
        zero     = (s[7:0] == 8'h00);
        negative = s[7];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_data = v;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Send A, B, OP with 'gap' idle cycles between bytes, then check both bytes.
    // 'inject' pulses 0xAA bytes while the result is in flight.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [5:0] vop,
                          input int gap, input bit inject,
                          input logic [7:0] eres, input logic [7:0] eflg);
        send_byte(va);
        idle(gap);
        send_byte(vb);
        idle(gap);
        send_byte({2'b00, vop});
        chk("busy_exec", busy, 1);
        chk("start_exec", tx_start, 0);
        step();
        chk("res_start", tx_start, 1);
        chk("res_data", tx_data, eres);
        step();
        chk("res_start_low", tx_start, 0);
        if (inject) begin
            for (int i = 0; i < 3; i++) begin
                send_byte(8'hAA);
                idle(1);
            end
            chk("inj_data", tx_data, eres);
        end
        idle(2);
        pulse_tx_done();
        chk("flg_start", tx_start, 1);
        chk("flg_data", tx_data, eflg);
        step();
        chk("flg_start_low", tx_start, 0);
        chk("busy_flg", busy, 1);
        idle(2);
        pulse_tx_done();
        chk("busy_done", busy, 0);
        chk("a_hold", a, va);
        chk("b_hold", b, vb);
        chk("op_hold", op, vop);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        idle(3);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_op", op, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic ADD, ADD with carry/zero, SUB negative.
        run_op(8'h05, 8'h03, 6'h20, 0, 0, 8'h08, 8'h00);
        run_op(8'hFF, 8'h01, 6'h20, 0, 0, 8'h00, 8'h06);
        run_op(8'h03, 8'h05, 6'h22, 0, 0, 8'hFE, 8'h01);

        // Timeout after A: ten idle cycles return to WAIT_A with A kept.
        send_byte(8'h11);
        idle(10);
        chk("to_a_kept", a, 8'h11);
        chk("to_busy", busy, 0);
        run_op(8'h02, 8'h02, 6'h24, 0, 0, 8'h02, 8'h00);

        // A byte arriving on the last allowed cycle is accepted.
        run_op(8'h07, 8'h01, 6'h20, 9, 0, 8'h08, 8'h00);

        // Stray rx bytes while the result is transmitting are dropped.
        run_op(8'h09, 8'h04, 6'h22, 0, 1, 8'h05, 8'h00);

        // Reset during WAIT_RES aborts the flag byte.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        idle(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_a", a, 0);
        chk("mid_rst_b", b, 0);
        chk("mid_rst_op", op, 0);
        chk("mid_rst_txd", tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        seen = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (tx_start) seen = 1'b1;
            step();
        end
        chk("no_flg_after_rst", seen, 0);
        run_op(8'h01, 8'h01, 6'h25, 0, 0, 8'h01, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
